// File: rtl/pkt_rx_pkg.sv
// Shared definitions for the pkt_rx endpoint: flit layout, type codes and FSM states.
package pkt_rx_pkg;

  // Flit is PKTW+1 bits: {type[1:0], data[7:0]}
  localparam int unsigned PKTW = 9;

  localparam logic [1:0] FT_EMPTY = 2'b00;
  localparam logic [1:0] FT_HEAD  = 2'b10;
  localparam logic [1:0] FT_BODY  = 2'b01;
  localparam logic [1:0] FT_TAIL  = 2'b11;

  localparam int unsigned TYPE_MSB = 9;
  localparam int unsigned TYPE_LSB = 8;
  localparam int unsigned TAG_MSB  = 7;
  localparam int unsigned TAG_LSB  = 4;
  localparam int unsigned DEST_MSB = 1;
  localparam int unsigned DEST_LSB = 0;

  // FIFO entry is {abort, last, data[7:0]}
  localparam int unsigned EntryW = 10;

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_e;

  function automatic logic [EntryW-1:0] mk_entry(input logic abort, input logic last,
                                                 input logic [7:0] data);
    return {abort, last, data};
  endfunction

endpackage

// File: rtl/pkt_rx_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra bit to tell full from empty.
module pkt_rx_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  // Storage array; on a full push+pop the overwritten slot is the one leaving this edge.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

  // Pointer advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_rx.sv
// Packet receive endpoint: frames the switch flit stream, checks dest, queues payload
// with last/abort markers. Define PKT_RX_STATS_EN to implement pkt_cnt/drop_cnt counters.
module pkt_rx
  import pkt_rx_pkg::*;
#(
  parameter int unsigned PORT_ID    = 0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [PKTW:0] flit_in_i,
  output logic [7:0]    data_out_o,
  output logic          data_last_o,
  output logic          data_abort_o,
  output logic          data_valid_o,
  input  logic          data_ready_i,
  output logic          hdr_valid_o,
  output logic [3:0]    hdr_tag_o,
  output logic          err_frame_o,
  output logic          err_misroute_o,
  output logic          err_overflow_o,
  output logic          busy_o,
  output logic [15:0]   pkt_cnt_o,
  output logic [15:0]   drop_cnt_o
);

  localparam logic [1:0] PortId = PORT_ID[1:0];
  localparam logic [7:0] MaxLen = MAX_LEN[7:0];

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [3:0]  tag_q, tag_d;
  logic        pending_abort_q, pending_abort_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        err_frame_q, err_frame_d;
  logic        err_misroute_q, err_misroute_d;
  logic        err_overflow_q, err_overflow_d;

  logic [1:0]        ftype;
  logic              take_hdr, abort_req, data_push, push_last;
  logic              abort_any, wr_abort, can_push, pop;
  logic              fifo_push, fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;

  assign ftype    = flit_in_i[TYPE_MSB:TYPE_LSB];
  assign pop      = data_ready_i & ~fifo_empty;
  assign can_push = ~fifo_full | pop;

  // Flit decode and next-state for framing FSM.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    tag_d          = tag_q;
    hdr_valid_d    = 1'b0;
    err_frame_d    = 1'b0;
    err_misroute_d = 1'b0;
    err_overflow_d = 1'b0;
    take_hdr       = 1'b0;
    abort_req      = 1'b0;
    data_push      = 1'b0;
    push_last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        case (ftype)
          FT_HEAD:          take_hdr = 1'b1;
          FT_BODY, FT_TAIL: err_frame_d = 1'b1;
          default: ;
        endcase
      end
      BODY: begin
        case (ftype)
          FT_HEAD: begin
            err_frame_d = 1'b1;
            abort_req   = 1'b1;
            take_hdr    = 1'b1;
          end
          FT_BODY, FT_TAIL: begin
            if (len_q == MaxLen) begin
              err_frame_d = 1'b1;
              abort_req   = 1'b1;
              state_d     = DROP;
            end else if (pending_abort_q || !can_push) begin
              // An outstanding abort owns the write port, so this flit is lost too
              err_overflow_d = 1'b1;
              abort_req      = 1'b1;
              state_d        = DROP;
            end else begin
              data_push = 1'b1;
              len_d     = len_q + 8'd1;
              if (ftype == FT_TAIL) begin
                push_last = 1'b1;
                state_d   = IDLE;
              end
            end
          end
          default: ;
        endcase
      end
      DROP: begin
        case (ftype)
          FT_HEAD: take_hdr = 1'b1;
          FT_TAIL: state_d = IDLE;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (take_hdr) begin
      if (flit_in_i[DEST_MSB:DEST_LSB] == PortId) begin
        tag_d       = flit_in_i[TAG_MSB:TAG_LSB];
        hdr_valid_d = 1'b1;
        len_d       = 8'd0;
        state_d     = BODY;
      end else begin
        err_misroute_d = 1'b1;
        state_d        = DROP;
      end
    end
  end

  // Abort markers win the write port. A new abort is written at once when there is room;
  // two aborts that cannot both be written (full FIFO, stalled consumer) merge into one.
  always_comb begin
    abort_any       = pending_abort_q | abort_req;
    wr_abort        = abort_any & can_push;
    pending_abort_d = (pending_abort_q & abort_req) | (abort_any & ~can_push);
    fifo_push       = wr_abort | data_push;
    fifo_wdata      = wr_abort ? mk_entry(1'b1, 1'b1, 8'h00)
                               : mk_entry(1'b0, push_last, flit_in_i[7:0]);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      len_q           <= '0;
      tag_q           <= '0;
      pending_abort_q <= 1'b0;
      hdr_valid_q     <= 1'b0;
      err_frame_q     <= 1'b0;
      err_misroute_q  <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      tag_q           <= tag_d;
      pending_abort_q <= pending_abort_d;
      hdr_valid_q     <= hdr_valid_d;
      err_frame_q     <= err_frame_d;
      err_misroute_q  <= err_misroute_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  pkt_rx_fifo #(
    .Width(EntryW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (fifo_push),
    .wdata_i(fifo_wdata),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Head entry is masked while empty so the data outputs read 0.
  assign data_valid_o                             = ~fifo_empty;
  assign {data_abort_o, data_last_o, data_out_o} = fifo_empty ? '0 : fifo_rdata;

  assign hdr_valid_o    = hdr_valid_q;
  assign hdr_tag_o      = tag_q;
  assign err_frame_o    = err_frame_q;
  assign err_misroute_o = err_misroute_q;
  assign err_overflow_o = err_overflow_q;
  assign busy_o         = (state_q != IDLE);

`ifdef PKT_RX_STATS_EN
  logic [15:0] pkt_cnt_q, drop_cnt_q;
  logic        pkt_inc;

  assign pkt_inc = data_push & push_last;

  // Good-packet and dropped-packet counters; both wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_q + {15'd0, pkt_inc};
      drop_cnt_q <= drop_cnt_q + {15'd0, abort_req} + {15'd0, err_misroute_d};
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  assign pkt_cnt_o  = '0;
  assign drop_cnt_o = '0;
`endif

endmodule
